// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: ALU operation codes, opcode/funct encodings and the
// control bundle passed from decode to execute.
package mips_ctrl_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // Bubble: no side effects, ALU left on add so code 011 can never appear.
  localparam ctrl_t CTRL_BUBBLE = '{
    alu_control: ALU_ADD,
    alu_src:     1'b0,
    reg_dst:     1'b0,
    reg_write:   1'b0,
    mem_write:   1'b0,
    mem_to_reg:  1'b0,
    branch:      1'b0,
    jump:        1'b0
  };

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode/funct decoder producing the control bundle and an illegal flag.
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        unique case (funct_i)
          FN_ADD:  ctrl_o.alu_control = ALU_ADD;
          FN_SUB:  ctrl_o.alu_control = ALU_SUB;
          FN_AND:  ctrl_o.alu_control = ALU_AND;
          FN_OR:   ctrl_o.alu_control = ALU_OR;
          FN_SLT:  ctrl_o.alu_control = ALU_SLT;
          default: begin
            ctrl_o    = CTRL_BUBBLE;
            illegal_o = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu_control = ALU_SUB;
        ctrl_o.branch      = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_ANDI: begin
        ctrl_o.alu_control = ALU_AND;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.reg_write   = 1'b1;
      end
      OP_ORI: begin
        ctrl_o.alu_control = ALU_OR;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.reg_write   = 1'b1;
      end
      OP_SLTI: begin
        ctrl_o.alu_control = ALU_SLT;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.reg_write   = 1'b1;
      end
      OP_J: ctrl_o.jump = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode-stage control unit with the ID/EX control register and stall/flush handling.
// Optional illegal-instruction trap support is built when ALU_ILLEGAL_TRAP_EN is defined.
module alu_decode_stage
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrD,
  input  logic             validD,
  input  logic             stall,
  input  logic             flush,
  output logic             validE,
  output logic [2:0]       aluControlE,
  output logic             aluSrcE,
  output logic             regDstE,
  output logic             regWriteE,
  output logic             memWriteE,
  output logic             memToRegE,
  output logic             branchE,
  output logic             jumpE,
  output logic             illegalE,
  output logic [CNT_W-1:0] illegalCount
);

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  logic  unused_instr;

  assign unused_instr = ^instrD[25:6];

  alu_op_decoder u_op_decoder (
    .opcode_i  (instrD[31:26]),
    .funct_i   (instrD[5:0]),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  ctrl_t ctrl_d, ctrl_q;
  logic  valid_d, valid_q;
  logic  load;

  // Flush beats stall; a fresh decode is taken only when neither is asserted.
  assign load = !flush && !stall;

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (flush || (load && !validD)) begin
      ctrl_d  = CTRL_BUBBLE;
      valid_d = 1'b0;
    end else if (load) begin
      ctrl_d  = dec_ctrl;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign validE      = valid_q;
  assign aluControlE = ctrl_q.alu_control;
  assign aluSrcE     = ctrl_q.alu_src;
  assign regDstE     = ctrl_q.reg_dst;
  assign regWriteE   = ctrl_q.reg_write;
  assign memWriteE   = ctrl_q.mem_write;
  assign memToRegE   = ctrl_q.mem_to_reg;
  assign branchE     = ctrl_q.branch;
  assign jumpE       = ctrl_q.jump;

`ifdef ALU_ILLEGAL_TRAP_EN
  logic             illegal_d, illegal_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             count_en;

  assign count_en = load && validD && dec_illegal;

  always_comb begin
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (flush) begin
      illegal_d = 1'b0;
    end else if (load) begin
      illegal_d = validD && dec_illegal;
    end
    if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign illegalE     = illegal_q;
  assign illegalCount = cnt_q;
`else
  logic unused_illegal;

  assign unused_illegal = dec_illegal;
  assign illegalE       = 1'b0;
  assign illegalCount   = '0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed scoreboard bench for alu_decode_stage; trap checks follow ALU_ILLEGAL_TRAP_EN.
module tb_alu_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instrD;
  logic        validD;
  logic        stall;
  logic        flush;
  logic        validE;
  logic [2:0]  aluControlE;
  logic        aluSrcE;
  logic        regDstE;
  logic        regWriteE;
  logic        memWriteE;
  logic        memToRegE;
  logic        branchE;
  logic        jumpE;
  logic        illegalE;
  logic [7:0]  illegalCount;

  alu_decode_stage #(.CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .instrD       (instrD),
    .validD       (validD),
    .stall        (stall),
    .flush        (flush),
    .validE       (validE),
    .aluControlE  (aluControlE),
    .aluSrcE      (aluSrcE),
    .regDstE      (regDstE),
    .regWriteE    (regWriteE),
    .memWriteE    (memWriteE),
    .memToRegE    (memToRegE),
    .branchE      (branchE),
    .jumpE        (jumpE),
    .illegalE     (illegalE),
    .illegalCount (illegalCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {valid, alu[2:0], src, dst, rw, mw, m2r, br, j, ill, cnt[7:0]}
  logic [19:0] sb[$];

  // {alu[2:0], src, dst, rw, mw, m2r, br, j, ill}
  localparam logic [10:0] BUB = {3'b010, 7'b0000000, 1'b0};
  logic        m_valid;
  logic [10:0] m_dec;
  logic [7:0]  m_cnt;

  function automatic logic [10:0] ref_decode(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: return {3'b010, 7'b0110000, 1'b0};
          6'b100010: return {3'b110, 7'b0110000, 1'b0};
          6'b100100: return {3'b000, 7'b0110000, 1'b0};
          6'b100101: return {3'b001, 7'b0110000, 1'b0};
          6'b101010: return {3'b111, 7'b0110000, 1'b0};
          default:   return {3'b010, 7'b0000000, 1'b1};
        endcase
      end
      6'b100011: return {3'b010, 7'b1010100, 1'b0};
      6'b101011: return {3'b010, 7'b1001000, 1'b0};
      6'b000100: return {3'b110, 7'b0000010, 1'b0};
      6'b001000: return {3'b010, 7'b1010000, 1'b0};
      6'b001100: return {3'b000, 7'b1010000, 1'b0};
      6'b001101: return {3'b001, 7'b1010000, 1'b0};
      6'b001010: return {3'b111, 7'b1010000, 1'b0};
      6'b000010: return {3'b010, 7'b0000001, 1'b0};
      default:   return {3'b010, 7'b0000000, 1'b1};
    endcase
  endfunction

  function automatic logic [19:0] model_vec();
`ifdef ALU_ILLEGAL_TRAP_EN
    return {m_valid, m_dec, m_cnt};
`else
    return {m_valid, m_dec[10:1], 1'b0, 8'h00};
`endif
  endfunction

  task automatic check(input string tag);
    logic [19:0] obs;
    logic [19:0] exp;
    obs = {validE, aluControlE, aluSrcE, regDstE, regWriteE, memWriteE, memToRegE,
           branchE, jumpE, illegalE, illegalCount};
    exp = sb.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    checks++;
    assert (aluControlE !== 3'b011) else begin
      errors++;
      $error("FAIL %s_alu011 observed=%b expected=not 011", tag, aluControlE);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_dec   = BUB;
    m_cnt   = 8'h00;
  endtask

  task automatic step(input logic [31:0] ins, input logic vd, input logic st, input logic fl,
                      input string tag);
    logic [10:0] d;
    instrD = ins;
    validD = vd;
    stall  = st;
    flush  = fl;
    if (fl) begin
      m_valid = 1'b0;
      m_dec   = BUB;
    end else if (!st) begin
      if (vd) begin
        d       = ref_decode(ins);
        m_valid = 1'b1;
        m_dec   = d;
        if (d[0] && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end else begin
        m_valid = 1'b0;
        m_dec   = BUB;
      end
    end
    sb.push_back(model_vec());
    @(posedge clk);
    #1;
    check(tag);
  endtask

  localparam logic [31:0] I_ADD  = 32'h0109_5020;
  localparam logic [31:0] I_SUB  = 32'h0000_0022;
  localparam logic [31:0] I_AND  = 32'h0000_0024;
  localparam logic [31:0] I_OR   = 32'h0000_0025;
  localparam logic [31:0] I_SLT  = 32'h0000_002A;
  localparam logic [31:0] I_LW   = 32'h8C00_0004;
  localparam logic [31:0] I_SW   = 32'hAC00_0008;
  localparam logic [31:0] I_BEQ  = 32'h1000_FFFF;
  localparam logic [31:0] I_ADDI = 32'h2000_0001;
  localparam logic [31:0] I_ANDI = 32'h3000_00FF;
  localparam logic [31:0] I_ORI  = 32'h3400_0F0F;
  localparam logic [31:0] I_SLTI = 32'h2800_0010;
  localparam logic [31:0] I_J    = 32'h0800_0100;
  localparam logic [31:0] I_BADOP = 32'hFC00_0000;
  localparam logic [31:0] I_BADFN = 32'h0000_003F;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    instrD = 32'h0000_0020;
    validD = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(model_vec());
    check("reset");

    reset = 1'b0;
    step(32'h0000_0020, 1'b1, 1'b0, 1'b0, "first_add");

    step(I_SUB,  1'b1, 1'b0, 1'b0, "sub");
    step(I_AND,  1'b1, 1'b0, 1'b0, "and");
    step(I_OR,   1'b1, 1'b0, 1'b0, "or");
    step(I_SLT,  1'b1, 1'b0, 1'b0, "slt");
    step(I_LW,   1'b1, 1'b0, 1'b0, "lw");
    step(I_SW,   1'b1, 1'b0, 1'b0, "sw");
    step(I_BEQ,  1'b1, 1'b0, 1'b0, "beq");
    step(I_ANDI, 1'b1, 1'b0, 1'b0, "andi");
    step(I_ORI,  1'b1, 1'b0, 1'b0, "ori");
    step(I_SLTI, 1'b1, 1'b0, 1'b0, "slti");
    step(I_ADDI, 1'b1, 1'b0, 1'b0, "addi");
    step(I_J,    1'b1, 1'b0, 1'b0, "j");
    step(I_ADD,  1'b1, 1'b0, 1'b0, "add_fields");

    step(I_LW, 1'b1, 1'b0, 1'b0, "stall_load_lw");
    for (int i = 0; i < 3; i++) step(I_SW, 1'b1, 1'b1, 1'b0, "stall_hold_lw");
    step(I_SW, 1'b1, 1'b0, 1'b0, "stall_release_sw");

    step(I_ADD, 1'b1, 1'b1, 1'b1, "stall_flush_bubble");
    step(I_ADD, 1'b1, 1'b0, 1'b0, "add_after_flush");
    step(I_ADD, 1'b0, 1'b0, 1'b0, "validd_low_bubble");

    step(I_BADFN, 1'b1, 1'b0, 1'b0, "bad_funct");
    step(I_BADOP, 1'b0, 1'b0, 1'b0, "illegal_not_valid");
    step(I_BADOP, 1'b1, 1'b0, 1'b1, "illegal_flushed");
    step(I_BADOP, 1'b1, 1'b0, 1'b0, "illegal_one");
    step(I_ADD,   1'b1, 1'b1, 1'b0, "illegal_stall_hold");
    step(I_ADD,   1'b1, 1'b0, 1'b0, "illegal_clear");
    step(I_BADOP, 1'b1, 1'b1, 1'b0, "illegal_stalled");

    for (int i = 0; i < 300; i++) step(I_BADOP, 1'b1, 1'b0, 1'b0, "illegal_saturate");
    step(I_BADFN, 1'b1, 1'b0, 1'b0, "illegal_at_max");

    step(I_LW, 1'b1, 1'b0, 1'b0, "pre_midreset_lw");
    stall = 1'b1;
    flush = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    sb.push_back(model_vec());
    check("midreset_immediate");
    @(posedge clk);
    #1;
    sb.push_back(model_vec());
    check("midreset_held");
    reset = 1'b0;
    step(I_ORI, 1'b1, 1'b0, 1'b0, "post_reset_ori");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
